// File: rtl/riscv_result_checker_if.sv
// Bus bundle for riscv_result_checker: checkpoint table writes, core observation inputs and verdict outputs.
// master drives table/core signals and observes the verdict; slave is the checker.
interface riscv_result_checker_if #(
  parameter int unsigned IDX_W = 5
);
  logic              TBL_WE;
  logic [IDX_W-1:0]  TBL_WA;
  logic [31:0]       TBL_NUM_INST;
  logic [31:0]       TBL_ANS;
  logic              START;
  logic [31:0]       NUM_INST;
  logic [31:0]       OUTPUT_PORT;
  logic              HALT;
  logic              BUSY;
  logic              DONE;
  logic              PASS;
  logic              FAIL;
  logic [2:0]        FAIL_CODE;
  logic [IDX_W-1:0]  FAIL_IDX;
  logic [31:0]       FAIL_VAL;
  logic [IDX_W:0]    PASS_CNT;
  logic [31:0]       CYCLE;

  modport master (
    output TBL_WE, TBL_WA, TBL_NUM_INST, TBL_ANS, START, NUM_INST, OUTPUT_PORT, HALT,
    input  BUSY, DONE, PASS, FAIL, FAIL_CODE, FAIL_IDX, FAIL_VAL, PASS_CNT, CYCLE
  );

  modport slave (
    input  TBL_WE, TBL_WA, TBL_NUM_INST, TBL_ANS, START, NUM_INST, OUTPUT_PORT, HALT,
    output BUSY, DONE, PASS, FAIL, FAIL_CODE, FAIL_IDX, FAIL_VAL, PASS_CNT, CYCLE
  );
endinterface

// File: rtl/riscv_result_checker.sv
// In-order checkpoint verifier for RISCV_TOP NUM_INST/OUTPUT_PORT/HALT with a registered verdict.
// Optional cycle timeout (fail code 4) is compiled in with `define RISCV_CHK_TIMEOUT_EN.
module riscv_result_checker #(
  parameter int unsigned NUM_TEST    = 17,
  parameter int unsigned IDX_W       = 5,
  parameter logic [31:0] TIMEOUT_CYC = 32'h000F_4240
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  riscv_result_checker_if.slave  bus
);

  localparam int unsigned    PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_TEST);

  localparam logic [2:0] CODE_MISMATCH = 3'd1;
  localparam logic [2:0] CODE_SKIP     = 3'd2;
  localparam logic [2:0] CODE_HALT     = 3'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, ptr_nxt;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic [2:0]         code_q, code_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        val_q, val_d, cyc_q, cyc_d, cyc_inc;

  logic [31:0]        tbl_num [NUM_TEST];
  logic [31:0]        tbl_ans [NUM_TEST];

  logic [IDX_W-1:0]   rd_idx;
  logic               pending, hit, match, mism, skip;

  // Checkpoint table: not reset, frozen while a run is in progress
  always_ff @(posedge CLK) begin
    if (bus.TBL_WE && (state_q != ST_RUN) && (PTR_W'(bus.TBL_WA) < LAST)) begin
      tbl_num[bus.TBL_WA] <= bus.TBL_NUM_INST;
      tbl_ans[bus.TBL_WA] <= bus.TBL_ANS;
    end
  end

  // Once every entry has matched, the table is no longer consulted
  assign pending = (ptr_q < LAST);
  assign rd_idx  = pending ? ptr_q[IDX_W-1:0] : '0;
  assign hit     = pending && (bus.NUM_INST == tbl_num[rd_idx]);
  assign match   = hit && (bus.OUTPUT_PORT == tbl_ans[rd_idx]);
  assign mism    = hit && (bus.OUTPUT_PORT != tbl_ans[rd_idx]);
  assign skip    = pending && (bus.NUM_INST > tbl_num[rd_idx]);
  assign ptr_nxt = match ? ptr_q + PTR_W'(1) : ptr_q;
  assign cyc_inc = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    code_d  = code_q;
    idx_d   = idx_q;
    val_d   = val_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.START) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          ptr_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          code_d  = '0;
          idx_d   = '0;
          val_d   = '0;
          cyc_d   = '0;
        end
      end
      ST_RUN: begin
        cyc_d = cyc_inc;
        ptr_d = ptr_nxt;
        // Failure priority: mismatch, skip, early halt, then timeout
        if (mism || skip || (bus.HALT && (ptr_nxt != LAST))) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          fail_d  = 1'b1;
          code_d  = mism ? CODE_MISMATCH : (skip ? CODE_SKIP : CODE_HALT);
          idx_d   = ptr_nxt[IDX_W-1:0];
          val_d   = bus.OUTPUT_PORT;
        end else if (bus.HALT) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end
`ifdef RISCV_CHK_TIMEOUT_EN
        else if (cyc_inc == TIMEOUT_CYC) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          fail_d  = 1'b1;
          code_d  = 3'd4;
          idx_d   = ptr_nxt[IDX_W-1:0];
          val_d   = bus.OUTPUT_PORT;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifndef RISCV_CHK_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      cyc_q   <= cyc_d;
    end
  end

  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;
  assign bus.FAIL      = fail_q;
  assign bus.FAIL_CODE = code_q;
  assign bus.FAIL_IDX  = idx_q;
  assign bus.FAIL_VAL  = val_q;
  assign bus.PASS_CNT  = ptr_q;
  assign bus.CYCLE     = cyc_q;

endmodule

// File: doc/riscv_result_checker.md
# riscv_result_checker

Synthesizable self-check stage sitting directly downstream of RISCV_TOP, consuming its NUM_INST, OUTPUT_PORT and HALT outputs. It holds a writable table of expected checkpoints, each an instruction count plus the OUTPUT_PORT value expected at that count, and verifies them in order while the program runs. It reports a registered pass/fail verdict, the failing checkpoint and a cycle count. This lets FPGA and gate-level runs self-check without a behavioural bench.

## Interface
- NUM_TEST, 17: number of checkpoint entries (1..2^IDX_W).
- IDX_W, 5: entry index width.
- TIMEOUT_CYC, 32'h000F_4240: cycle limit; used only when RISCV_CHK_TIMEOUT_EN is defined.

- CLK  in  1  clock; all state updates on posedge.
- RSTn  in  1  synchronous, active-low reset.
- TBL_WE  in  1  table write strobe.
- TBL_WA  in  IDX_W  table write index.
- TBL_NUM_INST  in  32  expected NUM_INST for the entry.
- TBL_ANS  in  32  expected OUTPUT_PORT for the entry.
- START  in  1  one-cycle pulse that begins checking.
- NUM_INST  in  32  retired-instruction count from the core.
- OUTPUT_PORT  in  32  core output port.
- HALT  in  1  core halt flag.
- BUSY  out  1  high in RUN.
- DONE  out  1  verdict valid; sticky until START or reset.
- PASS  out  1  all checkpoints matched before HALT.
- FAIL  out  1  a failure was detected.
- FAIL_CODE  out  3  0 none, 1 mismatch, 2 skipped checkpoint, 3 early halt, 4 timeout.
- FAIL_IDX  out  IDX_W  index of the entry pending at failure.
- FAIL_VAL  out  32  OUTPUT_PORT sampled at failure.
- PASS_CNT  out  IDX_W+1  checkpoints passed so far.
- CYCLE  out  32  cycles spent in RUN; saturates at 32'hFFFF_FFFF.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Reset clears every output and ptr to 0.
- Table contents are not reset. Reading an unwritten entry is an error the bench must avoid.
- Table writes are accepted in IDLE and DONE. Writes in RUN are ignored.
- Writes with TBL_WA ≥ NUM_TEST are ignored.
- IDLE/DONE + START → RUN. On entry: ptr, PASS_CNT, CYCLE, DONE, PASS, FAIL, FAIL_CODE, FAIL_IDX and FAIL_VAL are all cleared.
- START is ignored while in RUN.
- In RUN, each cycle compares the core inputs against entry[ptr], with exp = TBL_NUM_INST[ptr] and ans = TBL_ANS[ptr]:
  - ptr < NUM_TEST and NUM_INST == exp and OUTPUT_PORT == ans: ptr+1, PASS_CNT+1.
  - ptr < NUM_TEST and NUM_INST == exp and OUTPUT_PORT ≠ ans: FAIL, code 1.
  - ptr < NUM_TEST and NUM_INST > exp: FAIL, code 2. The core jumped past the checkpoint.
  - HALT with ptr == NUM_TEST after the match rule above is applied: PASS.
  - HALT with ptr < NUM_TEST after the match rule above is applied: FAIL, code 3.
- Simultaneous events:
  - A checkpoint match on the HALT cycle counts before the HALT verdict is taken.
  - Mismatch (code 1) and skip (code 2) take priority over HALT.
  - With timeout compiled in, any other failure takes priority over timeout.
- Every FAIL or PASS transitions to DONE with DONE=1. FAIL_IDX=ptr and FAIL_VAL=OUTPUT_PORT are captured on FAIL.
- Checkpoints must be loaded in strictly increasing TBL_NUM_INST order. Equal or decreasing entries make the later entry unreachable, and the run then fails with code 2 or 3.
- After the last entry matches, further NUM_INST values are not checked; only HALT is awaited.

## Timing
- All inputs are sampled at posedge. Verdict and status outputs are registered and appear 1 cycle after the deciding sample.
- A table write at edge N is usable by a START sampled at edge N+1.
- CYCLE increments on each RUN cycle, including the deciding cycle, and then freezes in DONE.
- BUSY rises 1 cycle after the START sample and falls together with the rise of DONE.
- RSTn low mid-run aborts to IDLE on the next edge with all outputs 0. The table is preserved.

## Configuration
- RISCV_CHK_TIMEOUT_EN defined: in RUN, when CYCLE reaches TIMEOUT_CYC without a verdict, the block sets FAIL with code 4, captures FAIL_IDX and FAIL_VAL, and enters DONE.
- RISCV_CHK_TIMEOUT_EN undefined: no timeout logic; code 4 is never produced; RUN lasts until a verdict or reset.

## Test plan
- Load 17 entries, {0x04, 0x0EEC} through {0x46, 0x0000}. Drive a matching NUM_INST/OUTPUT_PORT sequence, then HALT at NUM_INST 0x47. Expect DONE=1, PASS=1, PASS_CNT=17, FAIL_CODE=0.
- Same table, but drive OUTPUT_PORT=0x0EF1 at NUM_INST 0x0C (entry 4). Expect FAIL=1, FAIL_CODE=1, FAIL_IDX=4, FAIL_VAL=0x0EF1, PASS_CNT=4; later inputs change nothing.
- Let NUM_INST step 0x20→0x22 past entry 10 (0x21). Expect FAIL_CODE=2, FAIL_IDX=10.
- Assert HALT in the same cycle as a correct match at 0x46 (last entry). Expect PASS=1, PASS_CNT=17. Separately, HALT at 0x30 gives FAIL_CODE=3, FAIL_IDX=12.
- Pulse RSTn low mid-run, then issue START without reloading the table. Expect all outputs 0 after reset and a correct full pass, since the table is retained. Also write TBL_WA=3 during RUN and confirm entry 3 is unchanged.
- With RISCV_CHK_TIMEOUT_EN and TIMEOUT_CYC=100, hold NUM_INST at 0. Expect FAIL_CODE=4 and CYCLE=100, with DONE visible 1 cycle later.
